// File: rtl/grf_wb_arbiter_if.sv
// GRF write-back arbiter bus: W-stage source, long-latency source,
// and the registered GRF write port.
interface grf_wb_arbiter_if;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        lu_valid;
  logic [4:0]  lu_a3;
  logic [31:0] lu_wd;
  logic [31:0] lu_pc;
  logic        lu_ready;
  logic        stall_w;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [2:0]  pend_cnt;

  modport master (
    output w_we, w_a3, w_wd, w_pc,
    output lu_valid, lu_a3, lu_wd, lu_pc,
    input  lu_ready, stall_w, pend_cnt,
    input  grf_we, grf_a3, grf_wd, grf_pc
  );

  modport slave (
    input  w_we, w_a3, w_wd, w_pc,
    input  lu_valid, lu_a3, lu_wd, lu_pc,
    output lu_ready, stall_w, pend_cnt,
    output grf_we, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W stage vs. buffered long-latency results.
// Define GRF_WB_TRACE_EN to print one trace line per granted write.
module grf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  grf_wb_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t            mem [2**PW];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [2:0]      count;
  logic [SW-1:0]   starve;

  logic            non_empty;
  logic            ready;
  logic            stall;
  logic            w_req;
  logic            grant_w;
  logic            grant_h;
  logic            enq;
  ent_t            sel;

  logic            grf_we_q;
  logic [4:0]      grf_a3_q;
  logic [31:0]     grf_wd_q;
  logic [31:0]     grf_pc_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign non_empty = (count != 3'd0);
  assign ready     = (count < 3'(DEPTH));
  assign stall     = non_empty && (starve == SW'(STARVE_MAX));

  always_comb begin
    w_req   = bus.w_we && (bus.w_a3 != 5'd0);
    grant_h = stall || (!w_req && non_empty);
    grant_w = !stall && w_req;
    // $0 results complete the handshake but are dropped
    enq     = bus.lu_valid && ready && (bus.lu_a3 != 5'd0);
    sel     = '{a3: bus.w_a3, wd: bus.w_wd, pc: bus.w_pc};
    if (grant_h)
      sel = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr] <= '{a3: bus.lu_a3, wd: bus.lu_wd, pc: bus.lu_pc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (enq)
        wr_ptr <= nxt(wr_ptr);
      if (grant_h)
        rd_ptr <= nxt(rd_ptr);
      unique case ({enq, grant_h})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // non-empty without a head grant means W took the port
      if (!non_empty || grant_h)
        starve <= '0;
      else if (starve != SW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      grf_we_q <= grant_h || grant_w;
      if (grant_h || grant_w) begin
        grf_a3_q <= sel.a3;
        grf_wd_q <= sel.wd;
        grf_pc_q <= sel.pc;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && (grant_h || grant_w))
      $display("@%h: $%2d <= %h", sel.pc, sel.a3, sel.wd);
  end
`else
`endif

  assign bus.lu_ready = ready;
  assign bus.stall_w  = stall;
  assign bus.pend_cnt = count;
  assign bus.grf_we   = grf_we_q;
  assign bus.grf_a3   = grf_a3_q;
  assign bus.grf_wd   = grf_wd_q;
  assign bus.grf_pc   = grf_pc_q;

endmodule
